// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// well-known instruction encodings and the registered fetch payload.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [XLEN-1:0] HALT_INSTR_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] NOP_INSTR         = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Saturating increment for the delivered-instruction counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: control inputs, inst_mem port and the registered fetch output.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    import fetch_ctrl_pkg::*;

    logic              start;
    logic              stall;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_instr;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_instr;
    logic              halted;
    logic              fault;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        input  start, stall, redirect, redirect_pc, imem_instr,
        output imem_addr, if_valid, if_pc, if_instr, halted, fault, fetch_count
    );

    modport slave (
        output start, stall, redirect, redirect_pc, imem_instr,
        input  imem_addr, if_valid, if_pc, if_instr, halted, fault, fetch_count
    );

endinterface

// File: rtl/fetch_ctrl_pc_next_chk.sv
// Combinational next-PC helper: sequential increment, end-of-memory detect
// and redirect-target legality (word aligned and inside the memory span).
module pc_next_chk
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_plus4_c,
    output logic            seq_overflow_c,
    output logic            redir_bad_c
);

    always_comb begin
        pc_plus4_c     = pc + XLEN'(4);
        seq_overflow_c = &pc[ADDR_W+1:2];
        redir_bad_c    = redirect &&
                         ((redirect_pc[1:0] != 2'b00) ||
                          ((redirect_pc >> (ADDR_W + 2)) != XLEN'(0)));
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives inst_mem and registers the
// fetched instruction with its PC for decode; handles stall/redirect/halt/fault.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     ADDR_W     = 8,
    parameter logic [XLEN-1:0] HALT_INSTR = HALT_INSTR_EBREAK
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    fetch_pkt_t       pkt_q, pkt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  pc_plus4_c;
    logic             seq_overflow_c;
    logic             redir_bad_c;

    pc_next_chk #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_chk (
        .pc             (pc_q),
        .redirect       (bus.redirect),
        .redirect_pc    (bus.redirect_pc),
        .pc_plus4_c     (pc_plus4_c),
        .seq_overflow_c (seq_overflow_c),
        .redir_bad_c    (redir_bad_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            pkt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and fetch-register update; redirect outranks stall and halt.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                pkt_d.valid = 1'b0;
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.redirect) begin
                    pkt_d.valid = 1'b0;
                    if (redir_bad_c) state_d = ST_FAULT;
                    else             pc_d    = bus.redirect_pc;
                end else if (!bus.stall) begin
                    pkt_d.valid = 1'b1;
                    pkt_d.pc    = pc_q;
                    pkt_d.instr = bus.imem_instr;
                    cnt_d       = sat_inc(cnt_q);
                    if (bus.imem_instr == HALT_INSTR) begin
                        state_d = ST_HALT;
                        pc_d    = pc_plus4_c;
                    end else if (seq_overflow_c) begin
                        // Last word delivered; PC stays put rather than wrapping.
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = pc_plus4_c;
                    end
                end
            end
            ST_HALT: begin
                pkt_d.valid = 1'b0;
                if (bus.start) state_d = ST_RUN;
            end
            default: begin
                pkt_d.valid = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q[ADDR_W+1:2];
    assign bus.if_valid    = pkt_q.valid;
    assign bus.if_pc       = pkt_q.pc;
    assign bus.if_instr    = pkt_q.instr;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned SPAN  = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];

    fetch_ctrl_if #(.ADDR_W(AW)) bus();
    assign bus.imem_instr = mem[bus.imem_addr];

    fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_W     (AW),
        .HALT_INSTR (HALT_INSTR_EBREAK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    string       m_mode;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;
    int          m_cnt;

    task automatic model_reset();
        m_mode  = "IDLE";
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_ifpc  = 32'h0;
        m_instr = 32'h0;
        m_cnt   = 0;
    endtask

    // One clock of the fetch rules, using the inputs presented this cycle.
    task automatic model_step();
        logic [31:0] w;
        int          idx;
        if (m_mode == "IDLE") begin
            if (bus.start) m_mode = "RUN";
        end else if (m_mode == "RUN") begin
            if (bus.redirect) begin
                m_valid = 1'b0;
                if ((bus.redirect_pc % 4) != 0 || bus.redirect_pc >= SPAN) m_mode = "FAULT";
                else m_pc = bus.redirect_pc;
            end else if (!bus.stall) begin
                idx     = int'((m_pc / 4) % DEPTH);
                w       = mem[idx];
                m_valid = 1'b1;
                m_ifpc  = m_pc;
                m_instr = w;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (w == HALT_INSTR_EBREAK) begin
                    m_mode = "HALT";
                    m_pc   = m_pc + 4;
                end else if (m_pc + 4 >= SPAN) begin
                    m_mode = "FAULT";
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end else if (m_mode == "HALT") begin
            m_valid = 1'b0;
            if (bus.start) m_mode = "RUN";
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic load_program();
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = NOP_INSTR;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0013;
        mem[8] = 32'hDEAD_B0B3;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (bus.if_valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.if_valid); end
        if (bus.if_pc !== 32'h0)       begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.if_pc); end
        if (bus.if_instr !== 32'h0)    begin errors++; $display("FAIL reset_instr got=%h exp=0", bus.if_instr); end
        if (bus.fetch_count !== 16'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.fetch_count); end
        if (bus.halted !== 1'b0)       begin errors++; $display("FAIL reset_halted got=%0b exp=0", bus.halted); end
        if (bus.fault !== 1'b0)        begin errors++; $display("FAIL reset_fault got=%0b exp=0", bus.fault); end
        if (bus.imem_addr !== 8'd0)    begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.imem_addr); end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] exp_w [4];
        exp_w = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};
        do_reset();
        pulse_start();
        checks++;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL seq_first_edge_valid got=%0b exp=0", bus.if_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks += 3;
            if (bus.if_valid !== 1'b1)          begin errors++; $display("FAIL seq_valid[%0d] got=%0b exp=1", i, bus.if_valid); end
            if (bus.if_pc !== 32'(4 * i))       begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.if_pc, 32'(4 * i)); end
            if (bus.if_instr !== exp_w[i])      begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.if_instr, exp_w[i]); end
        end
        checks++;
        if (bus.fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count got=%0d exp=4", bus.fetch_count); end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        pulse_start();
        step();
        step();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 4;
            if (bus.if_pc !== 32'h4)             begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=4", i, bus.if_pc); end
            if (bus.if_instr !== 32'h00A0_0113)  begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=00a00113", i, bus.if_instr); end
            if (bus.imem_addr !== 8'd2)          begin errors++; $display("FAIL stall_addr[%0d] got=%0d exp=2", i, bus.imem_addr); end
            if (bus.fetch_count !== 16'd2)       begin errors++; $display("FAIL stall_count[%0d] got=%0d exp=2", i, bus.fetch_count); end
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h20;
        step();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        checks++;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got=%0b exp=0", bus.if_valid); end
        step();
        checks += 4;
        if (bus.if_valid !== 1'b1)         begin errors++; $display("FAIL redir_valid got=%0b exp=1", bus.if_valid); end
        if (bus.if_pc !== 32'h20)          begin errors++; $display("FAIL redir_pc got=%h exp=20", bus.if_pc); end
        if (bus.if_instr !== 32'hDEAD_B0B3) begin errors++; $display("FAIL redir_instr got=%h exp=deadb0b3", bus.if_instr); end
        if (bus.fetch_count !== 16'd3)     begin errors++; $display("FAIL redir_count got=%0d exp=3", bus.fetch_count); end
    endtask

    task automatic test_halt_resume();
        mem[4] = NOP_INSTR;
        mem[5] = HALT_INSTR_EBREAK;
        mem[6] = 32'h0070_0193;
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) step();
        checks += 3;
        if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL halt_instr_valid got=%0b exp=1", bus.if_valid); end
        if (bus.if_pc !== 32'h14)  begin errors++; $display("FAIL halt_instr_pc got=%h exp=14", bus.if_pc); end
        if (bus.halted !== 1'b1)   begin errors++; $display("FAIL halt_flag got=%0b exp=1", bus.halted); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        checks += 3;
        if (bus.if_valid !== 1'b0)  begin errors++; $display("FAIL halt_valid_drop got=%0b exp=0", bus.if_valid); end
        if (bus.halted !== 1'b1)    begin errors++; $display("FAIL halt_hold got=%0b exp=1", bus.halted); end
        if (bus.imem_addr !== 8'd6) begin errors++; $display("FAIL halt_pc_frozen got=%0d exp=6", bus.imem_addr); end
        pulse_start();
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_halted got=%0b exp=0", bus.halted); end
        step();
        checks += 3;
        if (bus.if_valid !== 1'b1)          begin errors++; $display("FAIL resume_valid got=%0b exp=1", bus.if_valid); end
        if (bus.if_pc !== 32'h18)           begin errors++; $display("FAIL resume_pc got=%h exp=18", bus.if_pc); end
        if (bus.if_instr !== 32'h0070_0193) begin errors++; $display("FAIL resume_instr got=%h exp=00700193", bus.if_instr); end
    endtask

    task automatic test_faults();
        logic [31:0] bad [2];
        bad = '{32'h22, 32'h400};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            pulse_start();
            step();
            bus.redirect    = 1'b1;
            bus.redirect_pc = bad[k];
            step();
            bus.redirect = 1'b0;
            checks += 2;
            if (bus.fault !== 1'b1)    begin errors++; $display("FAIL fault_redir[%h] got=%0b exp=1", bad[k], bus.fault); end
            if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL fault_redir_valid[%h] got=%0b exp=0", bad[k], bus.if_valid); end
            pulse_start();
            step();
            checks++;
            if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_sticky[%h] got=%0b exp=1", bad[k], bus.fault); end
        end
        mem[255] = NOP_INSTR;
        do_reset();
        checks++;
        if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_rst_clear got=%0b exp=0", bus.fault); end
        pulse_start();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h3FC;
        step();
        bus.redirect = 1'b0;
        checks++;
        if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_legal_redir got=%0b exp=0", bus.fault); end
        step();
        checks += 3;
        if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL end_valid got=%0b exp=1", bus.if_valid); end
        if (bus.if_pc !== 32'h3FC) begin errors++; $display("FAIL end_pc got=%h exp=3fc", bus.if_pc); end
        if (bus.fault !== 1'b1)    begin errors++; $display("FAIL end_fault got=%0b exp=1", bus.fault); end
        pulse_start();
        checks += 3;
        if (bus.if_valid !== 1'b0)    begin errors++; $display("FAIL end_valid_drop got=%0b exp=0", bus.if_valid); end
        if (bus.fault !== 1'b1)       begin errors++; $display("FAIL end_fault_hold got=%0b exp=1", bus.fault); end
        if (bus.imem_addr !== 8'd255) begin errors++; $display("FAIL end_pc_nowrap got=%0d exp=255", bus.imem_addr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.if_pc !== 32'h8) begin errors++; $display("FAIL arst_setup_pc got=%h exp=8", bus.if_pc); end
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (bus.if_valid !== 1'b0)     begin errors++; $display("FAIL arst_valid got=%0b exp=0", bus.if_valid); end
        if (bus.if_pc !== 32'h0)       begin errors++; $display("FAIL arst_pc got=%h exp=0", bus.if_pc); end
        if (bus.if_instr !== 32'h0)    begin errors++; $display("FAIL arst_instr got=%h exp=0", bus.if_instr); end
        if (bus.fetch_count !== 16'h0) begin errors++; $display("FAIL arst_count got=%0d exp=0", bus.fetch_count); end
        if (bus.imem_addr !== 8'd0)    begin errors++; $display("FAIL arst_addr got=%0d exp=0", bus.imem_addr); end
        #1;
        rst = 1'b0;
        model_reset();
        step();
        step();
        checks += 3;
        if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL arst_idle_valid got=%0b exp=0", bus.if_valid); end
        if (bus.halted !== 1'b0)   begin errors++; $display("FAIL arst_idle_halted got=%0b exp=0", bus.halted); end
        if (bus.fault !== 1'b0)    begin errors++; $display("FAIL arst_idle_fault got=%0b exp=0", bus.fault); end
    endtask

    task automatic test_random();
        int exp_addr;
        for (int i = 0; i < int'(DEPTH); i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? HALT_INSTR_EBREAK : $urandom;
        if (mem[DEPTH-1] == HALT_INSTR_EBREAK) mem[DEPTH-1] = NOP_INSTR;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_mode == "FAULT" && $urandom_range(0, 7) == 0) do_reset();
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.redirect = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 9))
                0:       bus.redirect_pc = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                1:       bus.redirect_pc = 32'h400 << $urandom_range(0, 21);
                default: bus.redirect_pc = 32'($urandom_range(DEPTH - 12, DEPTH - 1)) * 4
                                           - 32'($urandom_range(0, 1)) * 32'($urandom_range(0, 900));
            endcase
            step();
            exp_addr = int'((m_pc / 4) % DEPTH);
            checks += 5;
            if (bus.if_valid !== m_valid)           begin errors++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, bus.if_valid, m_valid); end
            if (bus.fetch_count !== 16'(m_cnt))     begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, bus.fetch_count, m_cnt); end
            if (bus.halted !== (m_mode == "HALT"))  begin errors++; $display("FAIL rand_halted cyc=%0d got=%0b exp=%s", cyc, bus.halted, m_mode); end
            if (bus.fault !== (m_mode == "FAULT"))  begin errors++; $display("FAIL rand_fault cyc=%0d got=%0b exp=%s", cyc, bus.fault, m_mode); end
            if (int'(bus.imem_addr) != exp_addr)    begin errors++; $display("FAIL rand_addr cyc=%0d got=%0d exp=%0d", cyc, bus.imem_addr, exp_addr); end
            if (m_valid) begin
                checks += 2;
                if (bus.if_pc !== m_ifpc)     begin errors++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", cyc, bus.if_pc, m_ifpc); end
                if (bus.if_instr !== m_instr) begin errors++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h", cyc, bus.if_instr, m_instr); end
            end
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();
        load_program();
        test_reset();
        test_seq_fetch();
        test_stall_redirect();
        test_halt_resume();
        test_faults();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
